// File: rtl/seven_seg_mux_bcd_pkg.sv
// seven_seg_pkg: shared segment patterns, digit codes and sizing helpers
package seven_seg_pkg;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] DASH = 4'hE;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] SEG_DASH = 7'h40;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    return (code <= 4'd9) ? SEG_DIGIT[code] : (code == DASH) ? SEG_DASH : 7'h00;
  endfunction
endpackage

// File: rtl/seven_seg_mux_bcd_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per clock
module bin2bcd_seq #(
  parameter int DATA_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       din,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  import seven_seg_pkg::*;
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = clog2(DATA_W + 1);
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b, input logic bit_in);
    logic [BW-1:0] a;
    a = b;
    for (int i = 0; i < NUM_DIGITS; i++) a[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
    return {a[BW-2:0], bit_in};
  endfunction
  // Start consumes the first bit straight from din, so a conversion spans exactly DATA_W edges
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sh <= din << 1;
        bcd <= dabble('0, din[DATA_W-1]);
        cnt <= CW'(DATA_W - 1);
        busy <= (DATA_W > 1);
        done <= (DATA_W == 1);
      end else if (busy) begin
        sh <= sh << 1;
        bcd <= dabble(bcd, sh[DATA_W-1]);
        cnt <= cnt - 1'b1;
        busy <= (cnt != CW'(1));
        done <= (cnt == CW'(1));
      end
    end
endmodule

// File: rtl/seven_seg_mux_bcd.sv
// seven_seg_mux_bcd: handshake-fed binary-to-BCD N-digit multiplexed 7-segment driver
// Define SEVEN_SEG_BLINK_EN to add the blink input and BLINK_HZ parameter.
module seven_seg_mux_bcd #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int REFRESH_HZ = 400,
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 14,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW = 1
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_HZ = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  blank_lz,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  overflow
);
  import seven_seg_pkg::*;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam int DIV = CLK_FREQ / REFRESH_HZ;
  localparam int RW = clog2(DIV);
  localparam int SW = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = pow10m1(NUM_DIGITS);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  state_t state;
  logic start, conv_busy, conv_done, blz_q, ovf_q, lead, an_en;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [3:0] disp [NUM_DIGITS];
  logic [3:0] next_disp [NUM_DIGITS];
  logic [RW-1:0] refresh_cnt;
  logic [SW-1:0] digit_sel;
  assign start = value_valid && value_ready && !conv_busy;
  bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .din(value),
    .busy(conv_busy),
    .done(conv_done),
    .bcd(bcd)
  );
  // Shape the finished conversion into digit codes: dashes on overflow, blanks above the leading digit
  always_comb begin
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead = lead && (bcd[4*i +: 4] == 4'd0);
      next_disp[i] = ovf_q ? DASH : (blz_q && lead && i != 0) ? BLANK : bcd[4*i +: 4];
    end
  end
  // Handshake FSM; display and overflow change together only in LOAD
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      value_ready <= 1'b1;
      overflow <= 1'b0;
      blz_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= (i == 0) ? 4'd0 : BLANK;
    end else
      case (state)
        IDLE: if (start) begin
          state <= CONV;
          value_ready <= 1'b0;
          blz_q <= blank_lz;
          ovf_q <= 64'(value) > MAX_VAL;
        end
        CONV: if (conv_done) state <= LOAD;
        LOAD: begin
          disp <= next_disp;
          overflow <= ovf_q;
          value_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // Free-running refresh divider and digit selector
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      refresh_cnt <= '0;
      digit_sel <= '0;
    end else begin
      refresh_cnt <= (refresh_cnt == RW'(DIV - 1)) ? '0 : refresh_cnt + 1'b1;
      if (refresh_cnt == RW'(DIV - 1)) digit_sel <= (digit_sel == SW'(NUM_DIGITS - 1)) ? '0 : digit_sel + 1'b1;
    end
`ifdef SEVEN_SEG_BLINK_EN
  localparam int BDIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BKW = (BDIV > 1) ? clog2(BDIV) : 1;
  logic [BKW-1:0] blink_cnt;
  logic phase_on;
  // Blink phase toggles every BDIV clocks, starting in the on phase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_cnt <= '0;
      phase_on <= 1'b1;
    end else begin
      blink_cnt <= (blink_cnt == BKW'(BDIV - 1)) ? '0 : blink_cnt + 1'b1;
      if (blink_cnt == BKW'(BDIV - 1)) phase_on <= !phase_on;
    end
  assign an_en = !(blink && !phase_on);
`else
  assign an_en = 1'b1;
`endif
  // Registered pin drivers; polarity is applied last
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      segments <= SEG_OFF;
      anodes <= AN_OFF;
    end else begin
      segments <= seg_decode(disp[digit_sel]) ^ SEG_OFF;
      anodes <= (an_en ? (NUM_DIGITS'(1) << digit_sel) : '0) ^ AN_OFF;
    end
endmodule

// File: tb/tb_seven_seg_mux_bcd.sv
// tb_seven_seg_mux_bcd: directed and randomized checks against a decimal-arithmetic display model
module tb_seven_seg_mux_bcd;
  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] DASH_SEG = 7'b0111111;
  logic clk = 0, reset_n = 0, value_valid = 0, blank_lz = 0;
  logic [13:0] value = '0;
  logic value_ready, overflow;
  logic [6:0] segments;
  logic [3:0] anodes;
`ifdef SEVEN_SEG_BLINK_EN
  logic blink = 0;
`endif
  int checks = 0, failures = 0;
  logic [6:0] exp_seg [4];
  logic exp_ovf;
  logic [6:0] obs_seg [4];
  int obs_hits [4];

  seven_seg_mux_bcd #(
    .CLK_FREQ(1600), .REFRESH_HZ(400), .NUM_DIGITS(4), .DATA_W(14), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
`ifdef SEVEN_SEG_BLINK_EN
    , .BLINK_HZ(100)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .value(value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank_lz(blank_lz),
`ifdef SEVEN_SEG_BLINK_EN
    .blink(blink),
`endif
    .segments(segments),
    .anodes(anodes),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model(input int v, input bit blz);
    int msd;
    msd = 0;
    exp_ovf = (v > 9999);
    for (int i = 0; i < 4; i++) if ((v / (10 ** i)) % 10 != 0) msd = i;
    for (int i = 0; i < 4; i++)
      exp_seg[i] = exp_ovf ? DASH_SEG : (blz && i > msd) ? OFF : PAT[(v / (10 ** i)) % 10];
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < 4; i++) begin
      obs_hits[i] = 0;
      obs_seg[i] = 'x;
    end
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (anodes === ~(4'b0001 << i)) begin
          obs_seg[i] = (obs_hits[i] == 0 || obs_seg[i] === segments) ? segments : 7'bx;
          obs_hits[i]++;
        end
    end
  endtask

  task automatic send(input int v, input bit blz, output int lowc);
    int t;
    t = 0;
    value = 14'(v);
    blank_lz = blz;
    value_valid = 1;
    while (value_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    value_valid = 0;
    lowc = 0;
    while (value_ready !== 1'b1 && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    repeat (2) @(negedge clk);
    checks += 4;
    if (value_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", value_ready); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (anodes !== 4'b1111) begin failures++; $display("FAIL reset_anodes: got %b want 1111", anodes); end
    if (segments !== OFF) begin failures++; $display("FAIL reset_segments: got %b want %b", segments, OFF); end
    reset_n = 1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((n - 1) / 4));
      checks += 3;
      if (anodes !== exp_an) begin failures++; $display("FAIL reset_scan_an[%0d]: got %b want %b", n, anodes, exp_an); end
      if (segments !== ((n <= 4) ? PAT[0] : OFF))
        begin failures++; $display("FAIL reset_scan_seg[%0d]: got %b want %b", n, segments, (n <= 4) ? PAT[0] : OFF); end
      if (value_ready !== 1'b1) begin failures++; $display("FAIL reset_idle_ready[%0d]: got %b want 1", n, value_ready); end
    end
  endtask

  task automatic test_value(input string name, input int v, input bit blz);
    int lowc;
    model(v, blz);
    send(v, blz, lowc);
    capture(16);
    checks += 2;
    if (lowc != 15) begin failures++; $display("FAIL %s_busy: got %0d cycles want 15", name, lowc); end
    if (overflow !== exp_ovf) begin failures++; $display("FAIL %s_overflow: got %b want %b", name, overflow, exp_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_hits[i] == 0 || obs_seg[i] !== exp_seg[i]) begin
        failures++;
        $display("FAIL %s_digit%0d: got seg=%b hits=%0d want seg=%b", name, i, obs_seg[i], obs_hits[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_random;
    int v;
    bit blz;
    for (int r = 0; r < 8; r++) begin
      v = $urandom_range(16383, 0);
      blz = 1'($urandom_range(1, 0));
      test_value($sformatf("rand%0d_v%0d_b%0d", r, v, blz), v, blz);
    end
  endtask

  task automatic test_back_to_back;
    int lowc, t;
    model(5, 0);
    value = 14'd5;
    blank_lz = 0;
    value_valid = 1;
    @(negedge clk);
    value = 14'd9999;
    lowc = 0;
    while (value_ready !== 1'b1 && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
    @(negedge clk);
    checks += 2;
    if (lowc != 15) begin failures++; $display("FAIL b2b_first_busy: got %0d cycles want 15", lowc); end
    if (value_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: ready got %b want 0", value_ready); end
    value_valid = 0;
    capture(12);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_hits[i] != 0 && obs_seg[i] !== exp_seg[i]) begin
        failures++;
        $display("FAIL b2b_first_digit%0d: got %b want %b", i, obs_seg[i], exp_seg[i]);
      end
    end
    model(9999, 0);
    t = 0;
    while (value_ready !== 1'b1 && t < 100) begin
      t++;
      @(negedge clk);
    end
    @(negedge clk);
    capture(16);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_hits[i] == 0 || obs_seg[i] !== exp_seg[i]) begin
        failures++;
        $display("FAIL b2b_second_digit%0d: got seg=%b hits=%0d want %b", i, obs_seg[i], obs_hits[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_conversion;
    value = 14'd1234;
    blank_lz = 0;
    value_valid = 1;
    @(negedge clk);
    value_valid = 0;
    repeat (5) @(negedge clk);
    reset_n = 0;
    #1;
    checks += 3;
    if (anodes !== 4'b1111) begin failures++; $display("FAIL midreset_anodes: got %b want 1111", anodes); end
    if (segments !== OFF) begin failures++; $display("FAIL midreset_segments: got %b want %b", segments, OFF); end
    if (value_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b want 1", value_ready); end
    @(negedge clk);
    reset_n = 1;
    model(0, 1);
    capture(24);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_hits[i] == 0 || obs_seg[i] !== exp_seg[i]) begin
        failures++;
        $display("FAIL midreset_digit%0d: got seg=%b hits=%0d want %b", i, obs_seg[i], obs_hits[i], exp_seg[i]);
      end
    end
  endtask

`ifdef SEVEN_SEG_BLINK_EN
  task automatic test_blink;
    bit off [32];
    int n_off, bad;
    blink = 1;
    n_off = 0;
    bad = 0;
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      off[s] = (anodes === 4'b1111);
      if (off[s]) n_off++;
    end
    for (int s = 0; s < 24; s++) if (off[s] == off[s + 8]) bad++;
    blink = 0;
    checks += 2;
    if (n_off != 16) begin failures++; $display("FAIL blink_off_count: got %0d want 16", n_off); end
    if (bad != 0) begin failures++; $display("FAIL blink_period: got %0d non-alternating samples want 0", bad); end
  endtask
`endif

  initial begin
    test_reset;
    test_value("v1234", 1234, 0);
    test_value("v7_blz", 7, 1);
    test_value("v0_blz", 0, 1);
    test_value("v12000", 12000, 0);
    test_value("v42", 42, 0);
    test_value("v9999", 9999, 1);
    test_value("v10000", 10000, 1);
    test_value("v100_blz", 100, 1);
    test_random;
    test_back_to_back;
    test_reset_mid_conversion;
`ifdef SEVEN_SEG_BLINK_EN
    test_blink;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
